// File: rtl/register_file_sb_if.sv
// register_file_sb_if: operand-store bus for register_file_sb.
//   Read ports : iRdEn / iRdAddr in, oRdData / oRdValid / oRdPending out
//   Write ports: iWrEn / iWrAddr / iWrData in
//   Scoreboard : iRsvEn / iRsvAddr in, oPendingMask out
//   Status     : oCollision out
// Port k of a flattened bus occupies slice [k*W +: W].
// The master modport drives requests; the slave modport is the register file.
interface register_file_sb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 2
) ();
    localparam int DEPTH = 1 << ADDR_W;

    logic [NUM_RD-1:0]        iRdEn;
    logic [NUM_RD*ADDR_W-1:0] iRdAddr;
    logic [NUM_RD*DATA_W-1:0] oRdData;
    logic [NUM_RD-1:0]        oRdValid;
    logic [NUM_RD-1:0]        oRdPending;
    logic [NUM_WR-1:0]        iWrEn;
    logic [NUM_WR*ADDR_W-1:0] iWrAddr;
    logic [NUM_WR*DATA_W-1:0] iWrData;
    logic                     iRsvEn;
    logic [ADDR_W-1:0]        iRsvAddr;
    logic [DEPTH-1:0]         oPendingMask;
    logic                     oCollision;

    modport master (
        output iRdEn, iRdAddr, iWrEn, iWrAddr, iWrData, iRsvEn, iRsvAddr,
        input  oRdData, oRdValid, oRdPending, oPendingMask, oCollision
    );

    modport slave (
        input  iRdEn, iRdAddr, iWrEn, iWrAddr, iWrData, iRsvEn, iRsvAddr,
        output oRdData, oRdValid, oRdPending, oPendingMask, oCollision
    );
endinterface

// File: rtl/register_file_sb.sv
// register_file_sb: multi-port register file with a per-register pending
// scoreboard, used as the operand store of the issue/execute stage.
//   iClock  : rising-edge clock
//   iResetN : asynchronous active-low reset (clears data, scoreboard, outputs)
//   bus     : register_file_sb_if.slave (read, write, reserve, status)
// Reads are registered and see same-edge writes (bypass). Register 0 is
// hardwired to zero and never pending. Highest-index write port wins on a
// same-address collision; a same-edge reserve beats a write's pending clear.
module register_file_sb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 2
) (
    input logic                iClock,
    input logic                iResetN,
    register_file_sb_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0]  regs_q, regs_d;
    logic [DEPTH-1:0]              pend_q, pend_d;
    logic                          coll_q, coll_d;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data_q;
    logic [NUM_RD-1:0]             rd_vld_q;
    logic [NUM_RD-1:0]             rd_pend_q;

    // Post-edge register and scoreboard image. Ports are applied in ascending
    // order so the highest-index port overrides; the reserve is applied last
    // so a newly issued producer keeps the register pending.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (bus.iWrEn[k] && (bus.iWrAddr[k*ADDR_W +: ADDR_W] != '0)) begin
                regs_d[bus.iWrAddr[k*ADDR_W +: ADDR_W]] = bus.iWrData[k*DATA_W +: DATA_W];
                pend_d[bus.iWrAddr[k*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (bus.iRsvEn && (bus.iRsvAddr != '0))
            pend_d[bus.iRsvAddr] = 1'b1;
        regs_d[0] = '0;
        pend_d[0] = 1'b0;
    end

    // Any pair of enabled write ports on the same nonzero address.
    always_comb begin
        coll_d = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (bus.iWrEn[i] && bus.iWrEn[j] &&
                    (bus.iWrAddr[i*ADDR_W +: ADDR_W] == bus.iWrAddr[j*ADDR_W +: ADDR_W]) &&
                    (bus.iWrAddr[i*ADDR_W +: ADDR_W] != '0))
                    coll_d = 1'b1;
            end
        end
    end

    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            regs_q <= '0;
            pend_q <= '0;
            coll_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
            coll_q <= coll_d;
        end
    end

    // Read ports sample the post-edge image, which gives write-through bypass
    // and same-edge reserve/clear visibility. Idle ports return to zero.
    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            rd_data_q <= '0;
            rd_vld_q  <= '0;
            rd_pend_q <= '0;
        end else begin
            for (int k = 0; k < NUM_RD; k++) begin
                if (bus.iRdEn[k]) begin
                    rd_data_q[k] <= regs_d[bus.iRdAddr[k*ADDR_W +: ADDR_W]];
                    rd_pend_q[k] <= pend_d[bus.iRdAddr[k*ADDR_W +: ADDR_W]];
                    rd_vld_q[k]  <= 1'b1;
                end else begin
                    rd_data_q[k] <= '0;
                    rd_pend_q[k] <= 1'b0;
                    rd_vld_q[k]  <= 1'b0;
                end
            end
        end
    end

    assign bus.oRdData      = rd_data_q;
    assign bus.oRdValid     = rd_vld_q;
    assign bus.oRdPending   = rd_pend_q;
    assign bus.oPendingMask = pend_q;
    assign bus.oCollision   = coll_q;
endmodule

// File: tb/tb_register_file_sb.sv
module tb_register_file_sb;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 4;
    localparam int NUM_WR = 2;

    logic iClock;
    logic iResetN;

    register_file_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();

    register_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
        .iClock  (iClock),
        .iResetN (iResetN),
        .bus     (bus)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    typedef struct packed {
        logic [3:0]       rd_en;
        logic [3:0][4:0]  rd_addr;
        logic [1:0]       wr_en;
        logic [1:0][4:0]  wr_addr;
        logic [1:0][15:0] wr_data;
        logic             rsv_en;
        logic [4:0]       rsv_addr;
        logic [3:0][15:0] exp_data;
        logic [3:0]       exp_valid;
        logic [3:0]       exp_pend;
        logic [31:0]      exp_mask;
        logic             exp_coll;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t tbl[12];
    vec_t post_rst;
    vec_t sb_q[$];

    function automatic vec_t mk(input logic [3:0] rde, input logic [19:0] rda,
                                input logic [1:0] wre, input logic [9:0] wra, input logic [31:0] wrd,
                                input logic rse, input logic [4:0] rsa,
                                input logic [63:0] ed, input logic [3:0] ev, input logic [3:0] ep,
                                input logic [31:0] em, input logic ec);
        vec_t v;
        v.rd_en = rde;   v.rd_addr = rda;
        v.wr_en = wre;   v.wr_addr = wra;   v.wr_data = wrd;
        v.rsv_en = rse;  v.rsv_addr = rsa;
        v.exp_data = ed; v.exp_valid = ev;  v.exp_pend = ep;
        v.exp_mask = em; v.exp_coll = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.iRdEn = '0; bus.iRdAddr = '0;
        bus.iWrEn = '0; bus.iWrAddr = '0; bus.iWrData = '0;
        bus.iRsvEn = 1'b0; bus.iRsvAddr = '0;
    endtask

    task automatic check_outputs(input string tag, input vec_t e);
        check({tag, ".rd_data"}, 64'(bus.oRdData), e.exp_data);
        check({tag, ".rd_valid"}, 64'(bus.oRdValid), 64'(e.exp_valid));
        check({tag, ".rd_pend"}, 64'(bus.oRdPending), 64'(e.exp_pend));
        check({tag, ".pend_mask"}, 64'(bus.oPendingMask), 64'(e.exp_mask));
        check({tag, ".collision"}, 64'(bus.oCollision), 64'(e.exp_coll));
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply_row(input string tag, input vec_t v);
        vec_t e;
        @(negedge iClock);
        bus.iRdEn = v.rd_en;   bus.iRdAddr = v.rd_addr;
        bus.iWrEn = v.wr_en;   bus.iWrAddr = v.wr_addr;   bus.iWrData = v.wr_data;
        bus.iRsvEn = v.rsv_en; bus.iRsvAddr = v.rsv_addr;
        sb_q.push_back(v);
        @(posedge iClock);
        #1;
        if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            check_outputs(tag, e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // {p3,p2,p1,p0} ordering in every concatenation below
        tbl[0]  = mk(4'b0000, 20'd0, 2'b00, 10'd0, 32'd0, 1'b0, 5'd0,
                     64'd0, 4'b0000, 4'b0000, 32'h0, 1'b0);
        // read r7 before it is written: old value 0
        tbl[1]  = mk(4'b0100, {5'd0,5'd7,5'd0,5'd0}, 2'b00, 10'd0, 32'd0, 1'b0, 5'd0,
                     64'd0, 4'b0100, 4'b0000, 32'h0, 1'b0);
        // bypass: write r7=BEEF and read it on the same edge
        tbl[2]  = mk(4'b0100, {5'd0,5'd7,5'd0,5'd0}, 2'b01, {5'd0,5'd7}, {16'h0,16'hBEEF}, 1'b0, 5'd0,
                     {16'h0,16'hBEEF,16'h0,16'h0}, 4'b0100, 4'b0000, 32'h0, 1'b0);
        // collision on r9: port 1 wins, bypass read sees 2222
        tbl[3]  = mk(4'b0001, {5'd0,5'd0,5'd0,5'd9}, 2'b11, {5'd9,5'd9}, {16'h2222,16'h1111}, 1'b0, 5'd0,
                     {16'h0,16'h0,16'h0,16'h2222}, 4'b0001, 4'b0000, 32'h0, 1'b1);
        // collision flag drops after one cycle
        tbl[4]  = mk(4'b1010, {5'd7,5'd0,5'd9,5'd0}, 2'b00, 10'd0, 32'd0, 1'b0, 5'd0,
                     {16'hBEEF,16'h0,16'h2222,16'h0}, 4'b1010, 4'b0000, 32'h0, 1'b0);
        // r0: both ports write it, reserve it; reads 0, never pending, no collision
        tbl[5]  = mk(4'b0011, 20'd0, 2'b11, {5'd0,5'd0}, {16'hFFFF,16'hFFFF}, 1'b1, 5'd0,
                     64'd0, 4'b0011, 4'b0000, 32'h0, 1'b0);
        // reserve r12, same-edge read sees pending
        tbl[6]  = mk(4'b0100, {5'd0,5'd12,5'd0,5'd0}, 2'b00, 10'd0, 32'd0, 1'b1, 5'd12,
                     64'd0, 4'b0100, 4'b0100, 32'h0000_1000, 1'b0);
        // write r12 clears pending
        tbl[7]  = mk(4'b1000, {5'd12,5'd0,5'd0,5'd0}, 2'b10, {5'd12,5'd0}, {16'h00A5,16'h0}, 1'b0, 5'd0,
                     {16'h00A5,16'h0,16'h0,16'h0}, 4'b1000, 4'b0000, 32'h0, 1'b0);
        // reserve and write r12 on the same edge: reserve wins
        tbl[8]  = mk(4'b0001, {5'd0,5'd0,5'd0,5'd12}, 2'b01, {5'd0,5'd12}, {16'h0,16'h00A5}, 1'b1, 5'd12,
                     {16'h0,16'h0,16'h0,16'h00A5}, 4'b0001, 4'b0001, 32'h0000_1000, 1'b0);
        // all four ports
        tbl[9]  = mk(4'b1111, {5'd0,5'd12,5'd9,5'd7}, 2'b00, 10'd0, 32'd0, 1'b0, 5'd0,
                     {16'h0,16'h00A5,16'h2222,16'hBEEF}, 4'b1111, 4'b0100, 32'h0000_1000, 1'b0);
        // port 1 idle: zero data/valid, others unaffected
        tbl[10] = mk(4'b1101, {5'd0,5'd12,5'd0,5'd7}, 2'b00, 10'd0, 32'd0, 1'b0, 5'd0,
                     {16'h0,16'h00A5,16'h0,16'hBEEF}, 4'b1101, 4'b0100, 32'h0000_1000, 1'b0);
        // write r5=1234, reserve r20 ahead of the mid-run reset
        tbl[11] = mk(4'b0001, {5'd0,5'd0,5'd0,5'd5}, 2'b10, {5'd5,5'd0}, {16'h1234,16'h0}, 1'b1, 5'd20,
                     {16'h0,16'h0,16'h0,16'h1234}, 4'b0001, 4'b0000, 32'h0010_1000, 1'b0);
        // after reset: r5 and r31 read 0, nothing pending
        post_rst = mk(4'b0011, {5'd0,5'd0,5'd31,5'd5}, 2'b00, 10'd0, 32'd0, 1'b0, 5'd0,
                      64'd0, 4'b0011, 4'b0000, 32'h0, 1'b0);

        iResetN = 1'b0;
        drive_idle();
        #12;
        check_outputs("reset", tbl[0]);
        @(negedge iClock);
        iResetN = 1'b1;

        for (int i = 0; i < 12; i++)
            apply_row($sformatf("row%0d", i), tbl[i]);

        // Asynchronous reset mid-cycle, no clock edge needed to clear.
        drive_idle();
        iResetN = 1'b0;
        #1;
        check_outputs("async_rst", tbl[0]);
        @(posedge iClock);
        #1;
        check_outputs("held_rst", tbl[0]);
        @(negedge iClock);
        iResetN = 1'b1;
        apply_row("post_rst", post_rst);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
